axi4_stream_null_byte_remover: RTL and testbench

Compacts an AXI4-Stream by removing null bytes (tkeep = 0) from every beat and repacking the surviving bytes, in order, into full output words of the same width. It sits directly upstream of the stream upsizer and guarantees the invariant the upsizer depends on:
- every output word is full (tkeep all ones), except the tlast word;
- the tlast word has low-aligned, contiguous tkeep.

---
 rtl/axi4_stream_null_byte_remover_if.sv | 33 +++
 rtl/axi4_stream_null_byte_remover.sv | 180 ++++++++++++++++++
 tb/tb_axi4_stream_null_byte_remover.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_null_byte_remover_if.sv
// -----------------------------------------------------------------------------
// axi4_stream_if
// Purpose : AXI4-Stream bundle shared by producer and consumer.
// Signals : tvalid/tready handshake, tdata, tstrb, tkeep, tlast, tid, tdest, tuser.
// Modports: master drives the payload and tvalid and samples tready;
//           slave samples the payload and tvalid and drives tready.
// -----------------------------------------------------------------------------
interface axi4_stream_if #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
) ();
    logic                       tvalid;
    logic                       tready;
    logic [TDATA_WIDTH-1:0]     tdata;
    logic [TDATA_WIDTH/8-1:0]   tstrb;
    logic [TDATA_WIDTH/8-1:0]   tkeep;
    logic                       tlast;
    logic [TID_WIDTH-1:0]       tid;
    logic [TDEST_WIDTH-1:0]     tdest;
    logic [TUSER_WIDTH-1:0]     tuser;

    modport master (
        output tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        input  tready
    );

    modport slave (
        input  tvalid, tdata, tstrb, tkeep, tlast, tid, tdest, tuser,
        output tready
    );
endinterface

// File: rtl/axi4_stream_null_byte_remover.sv
// -----------------------------------------------------------------------------
// axi4_stream_null_byte_remover
// Purpose : Removes null bytes (tkeep = 0) from an AXI4-Stream and repacks the
//           surviving bytes, in order, into full output words. Every output
//           word is full except the tlast word, whose tkeep is low-aligned and
//           contiguous.
// Ports   : clk_i  - clock
//           rst_i  - asynchronous, active-high reset
//           pkt_i  - input stream (slave modport), tkeep may be sparse
//           pkt_o  - compacted output stream (master modport)
// Option  : AXI4_STREAM_NULL_REMOVER_DROP_EMPTY_EN
//           defined   - a packet with no kept bytes produces no output
//           undefined - such a packet is emitted as one empty tlast word
// -----------------------------------------------------------------------------
module axi4_stream_null_byte_remover #(
    parameter int TDATA_WIDTH = 32,
    parameter int TID_WIDTH   = 1,
    parameter int TDEST_WIDTH = 1,
    parameter int TUSER_WIDTH = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    axi4_stream_if.slave  pkt_i,
    axi4_stream_if.master pkt_o
);
    localparam int W_B   = TDATA_WIDTH / 8;
    localparam int BUF_B = 2 * W_B;
    localparam int CNT_W = $clog2(BUF_B) + 1;
    localparam int IDX_W = $clog2(BUF_B);

    typedef logic [CNT_W-1:0] cnt_t;
    localparam cnt_t WB_C  = cnt_t'(W_B);
    localparam cnt_t BUF_C = cnt_t'(BUF_B);

    // Byte buffer: lane 0 is the oldest byte. Bytes at or above cnt_q are
    // always zero, which lets the low half drive pkt_o directly.
    logic [BUF_B*8-1:0]     data_q, data_d;
    logic [BUF_B-1:0]       strb_q, strb_d;
    logic [BUF_B-1:0]       vld_q,  vld_d;
    cnt_t                   cnt_q,  cnt_d;
    logic                   flush_q, flush_d;
    logic                   sop_q,   sop_d;
    logic                   tvalid_q, tvalid_d;
    logic                   tlast_q,  tlast_d;
    logic [TID_WIDTH-1:0]   tid_q,   tid_d;
    logic [TDEST_WIDTH-1:0] tdest_q, tdest_d;
    logic [TUSER_WIDTH-1:0] tuser_q, tuser_d;

    logic                   rx_ready_s;
    logic                   rx_s;
    logic                   tx_s;
    cnt_t                   pos_s;
    logic [IDX_W-1:0]       idx_s;

    // While flushing no input is taken; otherwise input is taken when the
    // upper half is free now or will be freed by this cycle's output handshake.
    assign rx_ready_s  = !flush_q && ((cnt_q <= WB_C) || pkt_o.tready);
    assign pkt_i.tready = rx_ready_s;
    assign rx_s        = pkt_i.tvalid && rx_ready_s;
    assign tx_s        = tvalid_q && pkt_o.tready;

    assign pkt_o.tvalid = tvalid_q;
    assign pkt_o.tlast  = tlast_q;
    assign pkt_o.tdata  = data_q[TDATA_WIDTH-1:0];
    assign pkt_o.tkeep  = vld_q[W_B-1:0];
    assign pkt_o.tstrb  = strb_q[W_B-1:0];
    assign pkt_o.tid    = tid_q;
    assign pkt_o.tdest  = tdest_q;
    assign pkt_o.tuser  = tuser_q;

    // Next-state: shift out the sent word, append packed input bytes, then
    // derive the registered tvalid/tlast from the resulting buffer state.
    always_comb begin
        data_d   = data_q;
        strb_d   = strb_q;
        vld_d    = vld_q;
        cnt_d    = cnt_q;
        flush_d  = flush_q;
        sop_d    = sop_q;
        tid_d    = tid_q;
        tdest_d  = tdest_q;
        tuser_d  = tuser_q;
        pos_s    = cnt_t'(0);
        idx_s    = {IDX_W{1'b0}};

        if (tx_s) begin
            data_d = data_q >> TDATA_WIDTH;
            strb_d = strb_q >> W_B;
            vld_d  = vld_q  >> W_B;
            if (cnt_q > WB_C) begin
                cnt_d = cnt_q - WB_C;
            end else begin
                cnt_d = cnt_t'(0);
            end
            if (tlast_q) begin
                flush_d = 1'b0;
            end else begin
                flush_d = flush_q;
            end
        end else begin
            cnt_d = cnt_q;
        end

        if (rx_s) begin
            // Kept lanes land at consecutive slots starting at the post-shift fill.
            pos_s = cnt_d;
            for (int i = 0; i < W_B; i++) begin
                if (pkt_i.tkeep[i]) begin
                    if (pos_s < BUF_C) begin
                        idx_s = pos_s[IDX_W-1:0];
                        data_d[{idx_s, 3'b000} +: 8] = pkt_i.tdata[i*8 +: 8];
                        strb_d[idx_s] = pkt_i.tstrb[i];
                        vld_d[idx_s]  = 1'b1;
                    end else begin
                        idx_s = {IDX_W{1'b0}};
                    end
                    pos_s = pos_s + cnt_t'(1);
                end else begin
                    pos_s = pos_s;
                end
            end
            cnt_d = pos_s;

            if (sop_q) begin
                tid_d   = pkt_i.tid;
                tdest_d = pkt_i.tdest;
                tuser_d = pkt_i.tuser;
            end else begin
                tid_d   = tid_q;
            end
            sop_d = pkt_i.tlast;

            if (pkt_i.tlast) begin
`ifdef AXI4_STREAM_NULL_REMOVER_DROP_EMPTY_EN
                // An empty packet never enters flush, so nothing is emitted.
                flush_d = (cnt_d != cnt_t'(0));
`else
                flush_d = 1'b1;
`endif
            end else begin
                flush_d = flush_d;
            end
        end else begin
            pos_s = cnt_t'(0);
        end

        // Holdback: a full word waits for more data unless the packet is closing.
        tvalid_d = (cnt_d > WB_C) || flush_d;
        tlast_d  = flush_d && (cnt_d <= WB_C);
    end

    // Buffer, control state and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            data_q   <= {(BUF_B*8){1'b0}};
            strb_q   <= {BUF_B{1'b0}};
            vld_q    <= {BUF_B{1'b0}};
            cnt_q    <= cnt_t'(0);
            flush_q  <= 1'b0;
            sop_q    <= 1'b1;
            tvalid_q <= 1'b0;
            tlast_q  <= 1'b0;
            tid_q    <= {TID_WIDTH{1'b0}};
            tdest_q  <= {TDEST_WIDTH{1'b0}};
            tuser_q  <= {TUSER_WIDTH{1'b0}};
        end else begin
            data_q   <= data_d;
            strb_q   <= strb_d;
            vld_q    <= vld_d;
            cnt_q    <= cnt_d;
            flush_q  <= flush_d;
            sop_q    <= sop_d;
            tvalid_q <= tvalid_d;
            tlast_q  <= tlast_d;
            tid_q    <= tid_d;
            tdest_q  <= tdest_d;
            tuser_q  <= tuser_d;
        end
    end
endmodule

// File: tb/tb_axi4_stream_null_byte_remover.sv
module tb_axi4_stream_null_byte_remover;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) in_if ();
    axi4_stream_if #(.TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)) out_if ();

    axi4_stream_null_byte_remover #(
        .TDATA_WIDTH(DW), .TID_WIDTH(1), .TDEST_WIDTH(1), .TUSER_WIDTH(1)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .pkt_i (in_if),
        .pkt_o (out_if)
    );

    int total = 0;
    int bad   = 0;
    int bp_mode = 0;  // 0: always ready, 1: random 50%, 2: never ready

    logic [31:0] cap_data[$];
    logic [3:0]  cap_keep[$];
    logic [3:0]  cap_strb[$];
    logic        cap_last[$];
    logic [2:0]  cap_side[$];
    logic [31:0] exp_data[$];
    logic [3:0]  exp_keep[$];
    logic        exp_last[$];
    logic [2:0]  exp_side[$];
    logic [7:0]  pkt_bytes[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expw(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [2:0] s);
        exp_data.push_back(d);
        exp_keep.push_back(k);
        exp_last.push_back(l);
        exp_side.push_back(s);
    endtask

    // Output-side ready driver and word capture (words seen here complete at the next edge).
    initial begin
        out_if.tready = 1'b1;
        forever begin
            @(negedge clk);
            if (bp_mode == 0)      out_if.tready = 1'b1;
            else if (bp_mode == 1) out_if.tready = 1'($urandom_range(0, 1));
            else                   out_if.tready = 1'b0;
            if (!rst && out_if.tvalid && out_if.tready) begin
                cap_data.push_back(out_if.tdata);
                cap_keep.push_back(out_if.tkeep);
                cap_strb.push_back(out_if.tstrb);
                cap_last.push_back(out_if.tlast);
                cap_side.push_back({out_if.tid, out_if.tdest, out_if.tuser});
            end
        end
    end

    task automatic send(input logic [3:0] keep, input logic [31:0] data, input logic last, input logic [2:0] side);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        @(negedge clk);
        in_if.tvalid = 1'b1;
        in_if.tkeep  = keep;
        in_if.tstrb  = keep;
        in_if.tdata  = data;
        in_if.tlast  = last;
        {in_if.tid, in_if.tdest, in_if.tuser} = side;
        while (!done) begin
            #1;
            if (in_if.tready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                n++;
                if (n > 2000) begin
                    total++;
                    bad++;
                    $error("FAIL rx_timeout observed=%0d expected=accept", n);
                    done = 1'b1;
                end else begin
                    @(negedge clk);
                end
            end
        end
        #1;
        in_if.tvalid = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        int n;
        check({tag, "_count"}, 32'(cap_data.size()), 32'(exp_data.size()));
        n = (cap_data.size() < exp_data.size()) ? cap_data.size() : exp_data.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_data"}, cap_data[i], exp_data[i]);
            check({tag, "_keep"}, 32'(cap_keep[i]), 32'(exp_keep[i]));
            check({tag, "_strb"}, 32'(cap_strb[i]), 32'(exp_keep[i]));
            check({tag, "_last"}, 32'(cap_last[i]), 32'(exp_last[i]));
            check({tag, "_side"}, 32'(cap_side[i]), 32'(exp_side[i]));
            if (!cap_last[i]) check({tag, "_full"}, 32'(cap_keep[i]), 32'hF);
        end
        cap_data.delete(); cap_keep.delete(); cap_strb.delete(); cap_last.delete(); cap_side.delete();
        exp_data.delete(); exp_keep.delete(); exp_last.delete(); exp_side.delete();
    endtask

    // Reference packer: kept bytes in arrival order, chunked into 4-byte words.
    task automatic model_pkt(input logic [2:0] side);
        int n;
        logic [31:0] d;
        logic [3:0]  k;
        n = pkt_bytes.size();
        if (n == 0) begin
`ifndef AXI4_STREAM_NULL_REMOVER_DROP_EMPTY_EN
            expw(32'h0, 4'h0, 1'b1, side);
`endif
        end else begin
            for (int s = 0; s < n; s += 4) begin
                d = 32'h0;
                k = 4'h0;
                for (int j = 0; j < 4; j++) begin
                    if (s + j < n) begin
                        d[j*8 +: 8] = pkt_bytes[s+j];
                        k[j] = 1'b1;
                    end
                end
                expw(d, k, (s + 4 >= n), side);
            end
        end
        pkt_bytes.delete();
    endtask

    initial begin
        logic [3:0]  rk;
        logic [31:0] rd;
        logic [2:0]  rs;
        int          nb;

        rst = 1'b1;
        in_if.tvalid = 1'b0; in_if.tdata = 32'h0; in_if.tkeep = 4'h0; in_if.tstrb = 4'h0;
        in_if.tlast = 1'b0; in_if.tid = 1'b0; in_if.tdest = 1'b0; in_if.tuser = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_tvalid", 32'(out_if.tvalid), 32'h0);
        check("rst_tlast",  32'(out_if.tlast),  32'h0);
        check("rst_tdata",  out_if.tdata,       32'h0);
        check("rst_tkeep",  32'(out_if.tkeep),  32'h0);
        check("rst_side",   32'({out_if.tid, out_if.tdest, out_if.tuser}), 32'h0);
        rst = 1'b0;
        #1;
        check("rst_tready", 32'(in_if.tready), 32'h1);

        // Dense packet with latency checks
        send(4'hF, 32'h44332211, 1'b0, 3'b000);
        check("dense_hold", 32'(out_if.tvalid), 32'h0);
        send(4'hF, 32'h88776655, 1'b0, 3'b000);
        check("dense_lat", 32'(out_if.tvalid), 32'h1);
        send(4'h3, 32'hEEDDAA99, 1'b1, 3'b000);
        repeat (10) @(negedge clk);
        expw(32'h44332211, 4'hF, 1'b0, 3'b000);
        expw(32'h88776655, 4'hF, 1'b0, 3'b000);
        expw(32'h0000AA99, 4'h3, 1'b1, 3'b000);
        compare_all("dense");

        // Sparse packet: A..F = AA,BB,CC,DD,EE,FF
        send(4'b0101, 32'h11BB22AA, 1'b0, 3'b101);
        send(4'b1010, 32'hDD33CC44, 1'b0, 3'b010);
        send(4'b1001, 32'hFF5566EE, 1'b1, 3'b010);
        repeat (10) @(negedge clk);
        expw(32'hDDCCBBAA, 4'hF, 1'b0, 3'b101);
        expw(32'h0000FFEE, 4'h3, 1'b1, 3'b101);
        compare_all("sparse");

        // Holdback: one full word must not be offered without more data
        send(4'hF, 32'h04030201, 1'b0, 3'b011);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("holdback_tvalid", 32'(out_if.tvalid), 32'h0);
        end
        send(4'b0001, 32'h99887705, 1'b1, 3'b011);
        repeat (10) @(negedge clk);
        expw(32'h04030201, 4'hF, 1'b0, 3'b011);
        expw(32'h00000005, 4'h1, 1'b1, 3'b011);
        compare_all("holdback");

        // Empty packet
        send(4'h0, 32'hDEADBEEF, 1'b1, 3'b100);
        repeat (10) @(negedge clk);
`ifndef AXI4_STREAM_NULL_REMOVER_DROP_EMPTY_EN
        expw(32'h0, 4'h0, 1'b1, 3'b100);
`endif
        compare_all("empty");

        // Null beat mid-packet is discarded
        send(4'h3, 32'h0000B2B1, 1'b0, 3'b110);
        send(4'h0, 32'h12345678, 1'b0, 3'b110);
        send(4'h1, 32'h000000B3, 1'b1, 3'b110);
        repeat (10) @(negedge clk);
        expw(32'h00B3B2B1, 4'h7, 1'b1, 3'b110);
        compare_all("nullbeat");

        // Async reset with 6 bytes buffered and flush pending
        bp_mode = 2;
        send(4'hF, 32'h0D0C0B0A, 1'b0, 3'b111);
        send(4'h3, 32'h00000F0E, 1'b1, 3'b111);
        @(negedge clk);
        check("pre_rst_tvalid", 32'(out_if.tvalid), 32'h1);
        #2 rst = 1'b1;
        #1;
        check("midrst_tvalid", 32'(out_if.tvalid), 32'h0);
        check("midrst_tready", 32'(in_if.tready),  32'h1);
        @(negedge clk);
        rst = 1'b0;
        bp_mode = 0;
        send(4'hF, 32'h24232221, 1'b0, 3'b001);
        send(4'hF, 32'h28272625, 1'b0, 3'b001);
        send(4'hC, 32'h2A290000, 1'b1, 3'b001);
        repeat (10) @(negedge clk);
        expw(32'h24232221, 4'hF, 1'b0, 3'b001);
        expw(32'h28272625, 4'hF, 1'b0, 3'b001);
        expw(32'h00002A29, 4'h3, 1'b1, 3'b001);
        compare_all("after_rst");

        // Random sparse packets under 50% output backpressure
        bp_mode = 1;
        for (int p = 0; p < 300; p++) begin
            nb = $urandom_range(1, 4);
            rs = 3'($urandom_range(0, 7));
            for (int b = 0; b < nb; b++) begin
                rk = 4'($urandom_range(0, 15));
                rd = $urandom;
                for (int j = 0; j < 4; j++) begin
                    if (rk[j]) pkt_bytes.push_back(rd[j*8 +: 8]);
                end
                send(rk, rd, (b == nb - 1), rs);
            end
            model_pkt(rs);
        end
        repeat (60) @(negedge clk);
        compare_all("random");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
